// File: rtl/dmem_arbiter_if.sv
// Two-port data-memory arbiter bus: requester handshakes plus the single memory port.
interface dmem_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic              lock0;
    logic              lock1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              rvalid0;
    logic              rvalid1;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1, mem_read_data,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
        output mem_address, mem_write_data, mem_write
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1, mem_read_data,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
        input  mem_address, mem_write_data, mem_write
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin ownership with a per-owner burst limit.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority (burst limit on port 1 only).
module dmem_arbiter #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MAX_BURST = 8
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d, cnt_inc;
    logic              beat0, beat1;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              rvalid0_q, rvalid1_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic              last_q, last_d;
`endif

    assign beat0       = (state_q == OWN0) && bus.req0;
    assign beat1       = (state_q == OWN1) && bus.req1;
    assign bus.gnt0    = (state_q == OWN0);
    assign bus.gnt1    = (state_q == OWN1);
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign cnt_inc     = (cnt_q >= BURST_MAX) ? BURST_MAX : cnt_q + 8'd1;

    always_comb begin
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        bus.mem_write      = 1'b0;
        case (state_q)
            OWN0: begin
                bus.mem_address    = bus.addr0;
                bus.mem_write_data = bus.wdata0;
                bus.mem_write      = beat0 && bus.we0;
            end
            OWN1: begin
                bus.mem_address    = bus.addr1;
                bus.mem_write_data = bus.wdata1;
                bus.mem_write      = beat1 && bus.we1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    state_d = OWN0;
`else
                    state_d = last_q ? OWN0 : OWN1;
`endif
                end else if (bus.req0) begin
                    state_d = OWN0;
                end else if (bus.req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!bus.req0) begin
                    state_d = bus.req1 ? OWN1 : IDLE;
                end else begin
                    cnt_d = cnt_inc;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                    if ((cnt_inc == BURST_MAX) && bus.req1 && !bus.lock0)
                        state_d = OWN1;
`endif
                end
            end
            OWN1: begin
                if (!bus.req1) begin
                    state_d = bus.req0 ? OWN0 : IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if ((cnt_inc == BURST_MAX) && bus.req0 && !bus.lock1)
                        state_d = OWN0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Any change of owner (including dropping to IDLE) restarts the burst count.
        if (state_d != state_q)
            cnt_d = '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        if ((state_d == OWN0) && (state_q != OWN0))
            last_d = 1'b0;
        else if ((state_d == OWN1) && (state_q != OWN1))
            last_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= beat0 && !bus.we0;
            rvalid1_q <= beat1 && !bus.we1;
            if (beat0 && !bus.we0)
                rdata0_q <= bus.mem_read_data;
            if (beat1 && !bus.we1)
                rdata1_q <= bus.mem_read_data;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q    <= last_d;
`endif
        end
    end
endmodule
